// File: rtl/pe_row_mac.sv
// Row-stationary PE: holds one filter row and a sliding ifmap window, and emits
// psum_in + dot(window, filter) through one time-multiplexed multiplier.
module pe_row_mac #(
   parameter int DATA_WIDTH = 16,
   parameter int FLTR_LEN   = 3
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    pe_en,
   output logic                    pe_ready,
   input  logic                    fltr_load,
   input  logic                    row_start,
   input  logic [DATA_WIDTH-1:0]   fltr_data_m2p,
   input  logic [DATA_WIDTH-1:0]   ifmap_data_m2p,
   input  logic [2*DATA_WIDTH-1:0] psum_data_m2p,
   output logic [2*DATA_WIDTH-1:0] psum_data_p2m,
   output logic                    pe_valid,
   input  logic                    pe_ack
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int CW = $clog2(FLTR_LEN + 1);
   localparam int TW = $clog2(FLTR_LEN);
   localparam logic [CW-1:0] FILL_FULL = CW'(FLTR_LEN);
   localparam logic [CW-1:0] FILL_ZERO = CW'(0);
   localparam logic [CW-1:0] FILL_ONE  = CW'(1);
   localparam logic [TW-1:0] IDX_LAST  = TW'(FLTR_LEN - 1);
   localparam logic [TW-1:0] IDX_ZERO  = TW'(0);
   localparam logic [TW-1:0] IDX_ONE   = TW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic                         ready_q, ready_d;
   logic                         valid_q, valid_d;
   logic [CW-1:0]                fill_q, fill_d;
   logic [TW-1:0]                wptr_q, wptr_d;
   logic [TW-1:0]                tap_q, tap_d;
   logic [PW-1:0]                acc_q, acc_d;
   logic [PW-1:0]                psum_q, psum_d;
   logic signed [DATA_WIDTH-1:0] w_q    [FLTR_LEN];
   logic signed [DATA_WIDTH-1:0] w_d    [FLTR_LEN];
   logic signed [DATA_WIDTH-1:0] fltr_q [FLTR_LEN];
   logic signed [DATA_WIDTH-1:0] fltr_d [FLTR_LEN];

   logic [CW-1:0]                fill_base_s;
   logic [CW-1:0]                fill_next_s;
   logic signed [PW-1:0]         prod_s;
   logic [PW-1:0]                acc_sum_s;

   // row_start discards the old fill count so stale pixels never reach a result
   assign fill_base_s = row_start ? FILL_ZERO : fill_q;
   assign fill_next_s = (fill_base_s == FILL_FULL) ? FILL_FULL : (fill_base_s + FILL_ONE);
   assign prod_s      = w_q[tap_q] * fltr_q[tap_q];
   assign acc_sum_s   = acc_q + prod_s;

   assign pe_ready      = ready_q;
   assign pe_valid      = valid_q;
   assign psum_data_p2m = psum_q;

   // Next-state and datapath decode for the IDLE / COMPUTE / DONE sequence
   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      valid_d = valid_q;
      fill_d  = fill_q;
      wptr_d  = wptr_q;
      tap_d   = tap_q;
      acc_d   = acc_q;
      psum_d  = psum_q;
      w_d     = w_q;
      fltr_d  = fltr_q;
      case (state_q)
         IDLE: begin
            if (pe_en) begin
               if (fltr_load) begin
                  fltr_d[wptr_q] = fltr_data_m2p;
                  wptr_d = (wptr_q == IDX_LAST) ? IDX_ZERO : (wptr_q + IDX_ONE);
               end else begin
                  for (int i = 0; i < FLTR_LEN - 1; i++) begin
                     w_d[i] = w_q[i+1];
                  end
                  w_d[FLTR_LEN-1] = ifmap_data_m2p;
                  fill_d = fill_next_s;
                  if (fill_next_s == FILL_FULL) begin
                     acc_d   = psum_data_m2p;
                     tap_d   = IDX_ZERO;
                     state_d = COMPUTE;
                     ready_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end
         COMPUTE: begin
            acc_d = acc_sum_s;
            if (tap_q == IDX_LAST) begin
               psum_d  = acc_sum_s;
               tap_d   = IDX_ZERO;
               state_d = DONE;
               valid_d = 1'b1;
            end else begin
               tap_d = tap_q + IDX_ONE;
            end
         end
         DONE: begin
            if (pe_ack) begin
               state_d = IDLE;
               valid_d = 1'b0;
               ready_d = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   // State, window, filter and result registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         fill_q  <= FILL_ZERO;
         wptr_q  <= IDX_ZERO;
         tap_q   <= IDX_ZERO;
         acc_q   <= {PW{1'b0}};
         psum_q  <= {PW{1'b0}};
         w_q     <= '{default: {DATA_WIDTH{1'b0}}};
         fltr_q  <= '{default: {DATA_WIDTH{1'b0}}};
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         fill_q  <= fill_d;
         wptr_q  <= wptr_d;
         tap_q   <= tap_d;
         acc_q   <= acc_d;
         psum_q  <= psum_d;
         w_q     <= w_d;
         fltr_q  <= fltr_d;
      end
   end

endmodule

// File: tb/tb_pe_row_mac.sv
// Directed, table-driven bench for pe_row_mac (K=3, DATA_WIDTH=16) with
// hand-written sequences for backpressure and mid-compute reset.
module tb_pe_row_mac;

   localparam int DW = 16;
   localparam int K  = 3;

   logic          clk;
   logic          rstn;
   logic          pe_en;
   logic          pe_ready;
   logic          fltr_load;
   logic          row_start;
   logic [DW-1:0] fltr_data_m2p;
   logic [DW-1:0] ifmap_data_m2p;
   logic [2*DW-1:0] psum_data_m2p;
   logic [2*DW-1:0] psum_data_p2m;
   logic          pe_valid;
   logic          pe_ack;

   int n_pass  = 0;
   int n_total = 0;

   pe_row_mac #(.DATA_WIDTH(DW), .FLTR_LEN(K)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .pe_en          (pe_en),
      .pe_ready       (pe_ready),
      .fltr_load      (fltr_load),
      .row_start      (row_start),
      .fltr_data_m2p  (fltr_data_m2p),
      .ifmap_data_m2p (ifmap_data_m2p),
      .psum_data_m2p  (psum_data_m2p),
      .psum_data_p2m  (psum_data_p2m),
      .pe_valid       (pe_valid),
      .pe_ack         (pe_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic          is_load;
      logic          rs;
      logic [DW-1:0] data;
      logic [31:0]   psum_in;
      logic          has_res;
      logic [31:0]   res;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(input logic ld, input logic rs, input logic [DW-1:0] d,
                               input logic [31:0] p, input logic hr, input logic [31:0] r);
      vec_t v;
      v.is_load = ld; v.rs = rs; v.data = d; v.psum_in = p; v.has_res = hr; v.res = r;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic load_w(input logic [DW-1:0] d);
      pe_en = 1'b1; fltr_load = 1'b1; fltr_data_m2p = d;
      @(posedge clk); #1;
      pe_en = 1'b0; fltr_load = 1'b0;
   endtask

   task automatic beat(input logic rs, input logic [DW-1:0] x, input logic [31:0] p);
      pe_en = 1'b1; fltr_load = 1'b0; row_start = rs; ifmap_data_m2p = x; psum_data_m2p = p;
      @(posedge clk); #1;
      pe_en = 1'b0; row_start = 1'b0;
   endtask

   // Called #1 after the completing edge; checks latency K and the result value
   task automatic wait_result(input string name, input logic [31:0] exp);
      int c;
      c = 0;
      while (!pe_valid && c < K + 4) begin
         @(posedge clk); #1;
         c++;
      end
      chk({name, "_latency"}, 64'(c), 64'(K));
      chk({name, "_value"}, 64'(psum_data_p2m), 64'(exp));
   endtask

   task automatic do_ack(input string name);
      pe_ack = 1'b1;
      @(posedge clk); #1;
      pe_ack = 1'b0;
      chk({name, "_ready_after_ack"}, 64'(pe_ready), 64'd1);
      chk({name, "_valid_after_ack"}, 64'(pe_valid), 64'd0);
   endtask

   initial begin
      tbl[0]  = mk(1'b1, 1'b0, 16'd1,      32'd0,          1'b0, 32'd0);
      tbl[1]  = mk(1'b1, 1'b0, 16'd2,      32'd0,          1'b0, 32'd0);
      tbl[2]  = mk(1'b1, 1'b0, 16'd3,      32'd0,          1'b0, 32'd0);
      tbl[3]  = mk(1'b0, 1'b1, 16'd1,      32'd0,          1'b0, 32'd0);
      tbl[4]  = mk(1'b0, 1'b0, 16'd2,      32'd0,          1'b0, 32'd0);
      tbl[5]  = mk(1'b0, 1'b0, 16'd3,      32'd10,         1'b1, 32'd24);
      tbl[6]  = mk(1'b0, 1'b0, 16'd4,      32'd0,          1'b1, 32'd20);
      tbl[7]  = mk(1'b0, 1'b0, 16'd5,      32'd100,        1'b1, 32'd126);
      tbl[8]  = mk(1'b0, 1'b1, 16'd7,      32'd0,          1'b0, 32'd0);
      tbl[9]  = mk(1'b0, 1'b0, 16'd8,      32'd0,          1'b0, 32'd0);
      tbl[10] = mk(1'b0, 1'b0, 16'd9,      32'd0,          1'b1, 32'd50);
      tbl[11] = mk(1'b0, 1'b1, 16'd1,      32'd0,          1'b0, 32'd0);
      tbl[12] = mk(1'b0, 1'b0, 16'd0,      32'd0,          1'b0, 32'd0);
      tbl[13] = mk(1'b0, 1'b0, 16'd0,      32'hFFFF_FFFF,  1'b1, 32'h0000_0000);
      tbl[14] = mk(1'b1, 1'b0, 16'hFFFF,   32'd0,          1'b0, 32'd0);
      tbl[15] = mk(1'b1, 1'b0, 16'hFFFF,   32'd0,          1'b0, 32'd0);
      tbl[16] = mk(1'b1, 1'b0, 16'hFFFF,   32'd0,          1'b0, 32'd0);
      tbl[17] = mk(1'b0, 1'b1, 16'h7FFF,   32'd0,          1'b0, 32'd0);
      tbl[18] = mk(1'b0, 1'b0, 16'h7FFF,   32'd0,          1'b0, 32'd0);
      tbl[19] = mk(1'b0, 1'b0, 16'h7FFF,   32'd0,          1'b1, 32'hFFFE_8003);
      tbl[20] = mk(1'b0, 1'b0, 16'hFFFE,   32'd5,          1'b1, 32'hFFFF_0009);

      rstn = 1'b0; pe_en = 1'b0; fltr_load = 1'b0; row_start = 1'b0; pe_ack = 1'b0;
      fltr_data_m2p = '0; ifmap_data_m2p = '0; psum_data_m2p = '0;
      #12;
      chk("reset_ready", 64'(pe_ready), 64'd1);
      chk("reset_valid", 64'(pe_valid), 64'd0);
      chk("reset_psum",  64'(psum_data_p2m), 64'd0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 21; i++) begin
         if (tbl[i].is_load) begin
            load_w(tbl[i].data);
            chk($sformatf("v%0d_load_ready", i), 64'(pe_ready), 64'd1);
         end else begin
            beat(tbl[i].rs, tbl[i].data, tbl[i].psum_in);
            if (tbl[i].has_res) begin
               chk($sformatf("v%0d_busy", i), 64'(pe_ready), 64'd0);
               wait_result($sformatf("v%0d", i), tbl[i].res);
               do_ack($sformatf("v%0d", i));
            end else begin
               chk($sformatf("v%0d_no_valid", i), 64'(pe_valid), 64'd0);
               chk($sformatf("v%0d_still_ready", i), 64'(pe_ready), 64'd1);
            end
         end
      end

      // Backpressure: result held, extra beat refused until ack
      load_w(16'd1); load_w(16'd2); load_w(16'd3);
      beat(1'b1, 16'd1, 32'd0);
      beat(1'b0, 16'd2, 32'd0);
      beat(1'b0, 16'd3, 32'd10);
      wait_result("bp", 32'd24);
      pe_en = 1'b1; fltr_load = 1'b0; row_start = 1'b1; ifmap_data_m2p = 16'd100; psum_data_m2p = 32'd9;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_valid_c%0d", c), 64'(pe_valid), 64'd1);
         chk($sformatf("bp_psum_c%0d", c), 64'(psum_data_p2m), 64'd24);
         chk($sformatf("bp_ready_c%0d", c), 64'(pe_ready), 64'd0);
      end
      pe_en = 1'b0; row_start = 1'b0;
      do_ack("bp");
      chk("bp_psum_kept", 64'(psum_data_p2m), 64'd24);
      beat(1'b0, 16'd4, 32'd0);
      wait_result("bp_next", 32'd20);
      do_ack("bp_next");

      // Asynchronous reset while COMPUTE is in progress
      beat(1'b0, 16'd5, 32'd0);
      @(posedge clk); #1;
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(pe_valid), 64'd0);
      chk("rst_mid_psum",  64'(psum_data_p2m), 64'd0);
      chk("rst_mid_ready", 64'(pe_ready), 64'd1);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", 64'(pe_ready), 64'd1);
      beat(1'b0, 16'd11, 32'd0);
      chk("post_rst_b1_no_valid", 64'(pe_valid), 64'd0);
      beat(1'b0, 16'd12, 32'd0);
      chk("post_rst_b2_no_valid", 64'(pe_valid), 64'd0);
      beat(1'b0, 16'd13, 32'd77);
      wait_result("post_rst", 32'd77);
      do_ack("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
